// File: rtl/motion_ctrl_pkg.sv
// rtl/motion_ctrl_pkg.sv - shared ALU operand codes, sequencer states and saturation limits
package motion_ctrl_pkg;

    // ALU src1 operand select codes
    localparam logic [2:0] SRC1_ACCUM     = 3'd0;
    localparam logic [2:0] SRC1_ITERM     = 3'd1;
    localparam logic [2:0] SRC1_ERR_DIV16 = 3'd2;
    localparam logic [2:0] SRC1_ERR       = 3'd3;
    localparam logic [2:0] SRC1_FWD       = 3'd4;

    // ALU src0 operand select codes
    localparam logic [2:0] SRC0_A2D    = 3'd0;
    localparam logic [2:0] SRC0_INTGRL = 3'd1;
    localparam logic [2:0] SRC0_ICOMP  = 3'd2;
    localparam logic [2:0] SRC0_PCOMP  = 3'd3;
    localparam logic [2:0] SRC0_PTERM  = 3'd4;

    // 12-bit signed saturation limits applied by the ALU
    localparam logic [11:0] SAT_POS = 12'h7FF;
    localparam logic [11:0] SAT_NEG = 12'h800;

    // One state per ALU step, plus idle and the result-valid cycle
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ERR  = 3'd1,
        ST_INTG = 3'd2,
        ST_ICMP = 3'd3,
        ST_PCMP = 3'd4,
        ST_ACC  = 3'd5,
        ST_OUT  = 3'd6,
        ST_DONE = 3'd7
    } seq_state_t;

endpackage

// File: rtl/pid_sequencer.sv
// rtl/pid_sequencer.sv - per-sample PID step sequencer driving the motion-control ALU
module pid_sequencer
    import motion_ctrl_pkg::*;
#(
    parameter int          MULT_CYCLES = 2,
    parameter logic [13:0] PTERM_VAL   = 14'h3680,
    parameter logic [11:0] ITERM_VAL   = 12'h500
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic               clr_intgrl,
    input  logic [11:0]        a2d_res,
    input  logic [11:0]        fwd,
    input  logic [15:0]        dst,
    output logic [2:0]         src1sel,
    output logic [2:0]         src0sel,
    output logic               multiply,
    output logic               sub,
    output logic               mult2,
    output logic               mult4,
    output logic               saturate,
    output logic [15:0]        accum,
    output logic [15:0]        pcomp,
    output logic [13:0]        pterm,
    output logic signed [11:0] error,
    output logic signed [11:0] intgrl,
    output logic signed [11:0] icomp,
    output logic [11:0]        iterm,
    output logic [11:0]        a2d_q,
    output logic [11:0]        fwd_q,
    output logic               busy,
    output logic               done,
    output logic signed [11:0] drive
);

    // Multiply steps last MULT_CYCLES cycles; the counter runs 0..MULT_CYCLES-1
    localparam logic [1:0] CNT_LAST = 2'(MULT_CYCLES - 1);

    seq_state_t state;
    seq_state_t state_nxt;
    logic [1:0] step_cnt;
    logic       mult_step;
    logic       step_last;

    assign pterm = PTERM_VAL;
    assign iterm = ITERM_VAL;

    // Only the two multiply steps span more than one cycle
    assign mult_step = (state == ST_ICMP) || (state == ST_PCMP);
    assign step_last = !mult_step || (step_cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Step-cycle counter: advances inside a multiply step, clears on its final cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt <= 2'd0;
        end else if (mult_step && !step_last) begin
            step_cnt <= step_cnt + 2'd1;
        end else begin
            step_cnt <= 2'd0;
        end
    end

    // Next-state and ALU control decode; controls are held for the whole step
    always_comb begin
        state_nxt = state;
        src1sel   = 3'd0;
        src0sel   = 3'd0;
        multiply  = 1'b0;
        sub       = 1'b0;
        mult2     = 1'b0;
        mult4     = 1'b0;
        saturate  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (go) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_ERR: begin
                busy      = 1'b1;
                src1sel   = SRC1_FWD;
                src0sel   = SRC0_A2D;
                sub       = 1'b1;
                saturate  = 1'b1;
                state_nxt = ST_INTG;
            end
            ST_INTG: begin
                busy      = 1'b1;
                src1sel   = SRC1_ERR_DIV16;
                src0sel   = SRC0_INTGRL;
                saturate  = 1'b1;
                state_nxt = ST_ICMP;
            end
            ST_ICMP: begin
                busy     = 1'b1;
                src1sel  = SRC1_ITERM;
                src0sel  = SRC0_INTGRL;
                multiply = 1'b1;
                if (step_last) begin
                    state_nxt = ST_PCMP;
                end
            end
            ST_PCMP: begin
                busy     = 1'b1;
                src1sel  = SRC1_ERR;
                src0sel  = SRC0_PTERM;
                multiply = 1'b1;
                if (step_last) begin
                    state_nxt = ST_ACC;
                end
            end
            ST_ACC: begin
                busy      = 1'b1;
                src1sel   = SRC1_FWD;
                src0sel   = SRC0_PCOMP;
                state_nxt = ST_OUT;
            end
            ST_OUT: begin
                busy      = 1'b1;
                src1sel   = SRC1_ACCUM;
                src0sel   = SRC0_ICOMP;
                saturate  = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand latch, integrator clear and dst capture on each step's final cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            a2d_q  <= 12'd0;
            fwd_q  <= 12'd0;
            error  <= 12'sd0;
            intgrl <= 12'sd0;
            icomp  <= 12'sd0;
            pcomp  <= 16'd0;
            accum  <= 16'd0;
            drive  <= 12'sd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // The clear lands before INTG even when go arrives in the same cycle
                    if (clr_intgrl) begin
                        intgrl <= 12'sd0;
                    end
                    if (go) begin
                        a2d_q <= a2d_res;
                        fwd_q <= fwd;
                    end
                end
                ST_ERR:  error  <= dst[11:0];
                ST_INTG: intgrl <= dst[11:0];
                ST_ICMP: begin
                    if (step_last) begin
                        icomp <= dst[11:0];
                    end
                end
                ST_PCMP: begin
                    if (step_last) begin
                        pcomp <= dst;
                    end
                end
                ST_ACC:  accum <= dst;
                ST_OUT:  drive <= dst[11:0];
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/pid_sequencer.md
Name: pid_sequencer

Overview:
- Control-side counterpart of the combinational motion-control ALU.
- Per sample, it issues the timed sequence of ALU select/operation codes, captures the ALU `dst` result into the PID working registers, and returns the final saturated drive value.
- Sits between the A2D sample path and the ALU: it owns accum, pcomp, error, intgrl and icomp, and feeds them back as ALU operands.

Parameters:
MULT_CYCLES, 2, cycles each multiply step is held before dst is captured (1..4)
PTERM_VAL, 14'h3680, constant proportional gain driven on pterm
ITERM_VAL, 12'h500, constant integral gain driven on iterm

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
go  in  1  new sample ready; sampled only in IDLE
clr_intgrl  in  1  zero intgrl; applied only in IDLE
a2d_res  in  12  measured value, latched on accepted go
fwd  in  12  setpoint, latched on accepted go
dst  in  16  ALU result
src1sel, src0sel  out  3 each  ALU operand selects
multiply, sub, mult2, mult4, saturate  out  1 each  ALU op controls
accum, pcomp  out  16 each  working registers to ALU
pterm  out  14  = PTERM_VAL
error, intgrl, icomp  out  12 each (signed)  working registers to ALU
iterm  out  12  = ITERM_VAL
a2d_q, fwd_q  out  12 each  latched operands to ALU
busy  out  1  high while sequence runs
done  out  1  one-cycle pulse, result valid
drive  out  12  signed saturated output

Behaviour:
- Reset: all registers, drive, busy, done = 0; selects/ops = 0; state IDLE. Reset mid-sequence aborts immediately; no partial write survives.
- ALU contract: dst = src1 ± src0 (sub=1 selects minus), or the scaled product when multiply=1. With saturate=1, dst is clamped to the 12-bit signed range 0x800..0x7FF (sign-extended). mult2 and mult4 are always 0 in this block.
- States: IDLE, ERR, INTG, ICMP, PCMP, ACC, OUT, DONE.
- IDLE: controls are 0. On go=1 at cycle t, latch a2d_q and fwd_q, go to ERR at t+1, and set busy.
- Step table (src1/src0, ops, destination):
  - ERR: FWD/A2D, sub+sat, error ← dst[11:0] (1 cycle).
  - INTG: ERR_DIV16/INTGRL, sat, intgrl ← dst[11:0] (1 cycle).
  - ICMP: ITERM/INTGRL, multiply, icomp ← dst[11:0] (MULT_CYCLES cycles).
  - PCMP: ERR/PTERM, multiply, pcomp ← dst (MULT_CYCLES cycles).
  - ACC: FWD/PCOMP, add, accum ← dst (1 cycle).
  - OUT: ACCUM/ICOMP, sat, drive ← dst[11:0] (1 cycle).
- Capture timing: dst is captured on the final cycle of each step. Controls are held stable for the whole step. A step-cycle counter is used for the multiply steps.
- Timing with MULT_CYCLES=2: busy is high t+1..t+8; DONE state at t+9 with done=1 and busy=0; IDLE at t+10. A go in the DONE cycle is ignored. A go while busy is ignored (not queued).
- clr_intgrl in IDLE: intgrl ← 0 next cycle. If go and clr_intgrl arrive together, the clear is applied first, so INTG uses intgrl=0.
- drive holds its value between sequences. The working registers hold their values across sequences (intgrl accumulates).

Decomposition:
- motion_ctrl_pkg:
  - SRC1 codes: ACCUM=0, ITERM=1, ERR_DIV16=2, ERR=3, FWD=4.
  - SRC0 codes: A2D=0, INTGRL=1, ICOMP=2, PCOMP=3, PTERM=4.
  - Sequencer state enum.
  - Saturation limits 12'h7FF and 12'h800.
- Single module with no sub-module. The step-to-control mapping is a case-based decode inside it.

Test Plan:
1. Reset: assert rst mid-PCMP. Next cycle all outputs are 0, busy=0, state IDLE; a following go runs a full clean sequence.
2. Basic sequence: a2d_res=0x100, fwd=0x180, go at t; scripted dst returns 0x0080, 0x0008, 0x0004, 0x0100, 0x0280, 0x0284. Required: error=0x080 and intgrl=0x008 after their steps; t+1 controls are src1=FWD, src0=A2D, sub=1, saturate=1; done at t+9 with drive=0x284.
3. Multiply hold: with MULT_CYCLES=3, multiply=1 for exactly 3 cycles per multiply step. dst changes in non-final cycles are not captured; done arrives at t+11.
4. Saturated drive: scripted OUT dst=0xF800 gives drive=0x800. Integrator accumulation: two sequences with dst(INTG)=0x7FF then 0x7FF give intgrl=0x7FF.
5. go while busy at t+3 is ignored: a2d_q is unchanged and exactly one done pulse occurs.
6. clr_intgrl together with go, prior intgrl=0x123: intgrl=0 during INTG (src0 operand 0x000).
